// File: rtl/ivl_uvm_ovl_pkg.sv
// ivl_uvm_ovl_pkg
// Shared types for the OVL fire collector, its reporting block and the
// monitor that consumes fire events.
//   id_width()  : index width for n checkers, never below 1 bit
//   ID_W        : index width for the default 4-checker bank
//   ovl_evt_t   : {id, ts} event record at the default widths
package ivl_uvm_ovl_pkg;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_NUM_CHK = 4;
    localparam int DEF_TS_W    = 16;
    localparam int ID_W        = id_width(DEF_NUM_CHK);

    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [DEF_TS_W-1:0] ts;
    } ovl_evt_t;

endpackage

// File: rtl/ivl_uvm_ovl_evt_fifo.sv
// ivl_uvm_ovl_evt_fifo
// Show-ahead synchronous FIFO of fire events.
// Ports:
//   clock, reset  : clock, asynchronous active-low reset (empties the FIFO)
//   flush         : synchronous empty, wins over push and pop
//   push, wdata   : write request and data (ignored when full without a pop)
//   pop           : consume the head entry (ignored when empty)
//   rdata         : head entry, zero while empty
//   empty, full   : occupancy flags
module ivl_uvm_ovl_evt_fifo
    import ivl_uvm_ovl_pkg::*;
#(
    parameter type T     = ovl_evt_t,
    parameter int  DEPTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic empty,
    output logic full
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    T               mem [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO may still accept.
    assign do_push = push && (!full || do_pop);

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; only the pointers define validity,
    // and leaving the RAM unreset lets it map onto plain memory cells.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

    // Mask the head while empty so the outputs read zero instead of stale data.
    assign rdata = empty ? T'('0) : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/ivl_uvm_ovl_fire_collector.sv
// ivl_uvm_ovl_fire_collector
// Collects fire bits from a bank of OVL checkers: per-checker saturating fire
// counters, a free-running timestamp, one pending event slot per checker and
// a lowest-index-first arbiter feeding a show-ahead event FIFO.
// Ports:
//   clock, reset        : clock, asynchronous active-low reset
//   enable              : fire capture enable (timestamp always runs)
//   clear               : synchronous clear of counts, overrun, pending, FIFO
//   fire[NUM_CHK]       : per-checker fire bits
//   evt_valid/ready     : head event handshake
//   evt_id, evt_ts      : checker index and capture timestamp of head event
//   cnt_sel, cnt_out    : combinational read of one fire counter
//   overrun[NUM_CHK]    : sticky, a pending event was overwritten
//   fifo_full           : event FIFO is full
module ivl_uvm_ovl_fire_collector
    import ivl_uvm_ovl_pkg::*;
#(
    parameter  int NUM_CHK    = 4,
    parameter  int CNT_W      = 8,
    parameter  int TS_W       = 16,
    parameter  int FIFO_DEPTH = 8,
    localparam int SEL_W      = id_width(NUM_CHK)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [NUM_CHK-1:0] fire,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [SEL_W-1:0]   evt_id,
    output logic [TS_W-1:0]    evt_ts,
    input  logic [SEL_W-1:0]   cnt_sel,
    output logic [CNT_W-1:0]   cnt_out,
    output logic [NUM_CHK-1:0] overrun,
    output logic               fifo_full
);

    localparam int              CNT_SLOTS = 1 << SEL_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef struct packed {
        logic [SEL_W-1:0] id;
        logic [TS_W-1:0]  ts;
    } evt_t;

    logic [TS_W-1:0]    ts;
    logic [CNT_W-1:0]   cnt      [NUM_CHK];
    logic [TS_W-1:0]    pend_ts  [NUM_CHK];
    logic [NUM_CHK-1:0] pend;

    logic [NUM_CHK-1:0] push_oh;
    logic               any_pend;
    logic               push_en;
    evt_t               push_evt;
    evt_t               head_evt;
    logic               fifo_empty;

    // Free-running timestamp; wraps naturally and ignores clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ts <= '0;
        else        ts <= ts + 1'b1;
    end

    // Priority arbiter: lowest-index pending checker wins, held off while full.
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        push_oh  = '0;
        any_pend = 1'b0;
        push_evt = '0;
        for (int i = 0; i < NUM_CHK; i++) begin
            if (pend[i] && !any_pend) begin
                any_pend    = 1'b1;
                push_oh[i]  = 1'b1;
                push_evt.id = SEL_W'(i);
                push_evt.ts = pend_ts[i];
            end
        end
        if (fifo_full) push_oh = '0;
    end

    assign push_en = any_pend && !fifo_full;

    // Per-checker capture. A fire on the checker being pushed this cycle just
    // refills its slot; only a fire on a slot that stays occupied is an overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend    <= '0;
            overrun <= '0;
            for (int i = 0; i < NUM_CHK; i++) begin
                cnt[i]     <= '0;
                pend_ts[i] <= '0;
            end
        end else if (clear) begin
            pend    <= '0;
            overrun <= '0;
            for (int i = 0; i < NUM_CHK; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CHK; i++) begin
                if (enable && fire[i]) begin
                    if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
                    pend_ts[i] <= ts;
                    pend[i]    <= 1'b1;
                    if (pend[i] && !push_oh[i]) overrun[i] <= 1'b1;
                end else if (push_oh[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Counter read port padded to a power of two so any cnt_sel is in range.
    logic [CNT_W-1:0] cnt_view [CNT_SLOTS];

    for (genvar j = 0; j < CNT_SLOTS; j++) begin : g_view
        if (j < NUM_CHK) begin : g_real
            assign cnt_view[j] = cnt[j];
        end else begin : g_pad
            assign cnt_view[j] = '0;
        end
    end

    assign cnt_out = cnt_view[cnt_sel];

    ivl_uvm_ovl_evt_fifo #(
        .T     (evt_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (clear),
        .push  (push_en),
        .wdata (push_evt),
        .pop   (evt_ready),
        .rdata (head_evt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign evt_valid = !fifo_empty;
    assign evt_id    = head_evt.id;
    assign evt_ts    = head_evt.ts;

endmodule

// File: tb/tb_ivl_uvm_ovl_fire_collector.sv
// tb_ivl_uvm_ovl_fire_collector
// Directed bench for the OVL fire collector: reset state, single and
// simultaneous fires, backpressure with overrun, saturation, clear, enable
// and a reset during drain.
module tb_ivl_uvm_ovl_fire_collector;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear;
    logic [3:0] fire;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [15:0] evt_ts;
    logic [1:0] cnt_sel;
    logic [3:0] cnt_out;
    logic [3:0] overrun;
    logic       fifo_full;

    int checks = 0;
    int errors = 0;
    // Cycles since reset release; equals the timestamp the next edge samples.
    int cyc;

    ivl_uvm_ovl_fire_collector #(
        .NUM_CHK    (4),
        .CNT_W      (4),
        .TS_W       (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .fire      (fire),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_ts    (evt_ts),
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out),
        .overrun   (overrun),
        .fifo_full (fifo_full)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_cyc(input int t);
        int guard = 0;
        while (cyc < t && guard < 1000) begin
            @(negedge clock);
            guard++;
        end
        if (cyc != t) check("wait_cyc_bound", cyc, t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        clear     = 1'b0;
        fire      = '0;
        evt_ready = 1'b0;
        cnt_sel   = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Reset release: idle for 10 cycles.
        repeat (10) @(negedge clock);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_id", evt_id, 0);
        check("rst_evt_ts", evt_ts, 0);
        check("rst_overrun", overrun, 0);
        check("rst_fifo_full", fifo_full, 0);
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            check("rst_cnt_out", cnt_out, 0);
        end

        // Single fire on checker 2 sampled at ts=5.
        do_reset();
        wait_cyc(5);
        fire = 4'b0100;
        @(negedge clock);
        fire    = '0;
        cnt_sel = 2'd2;
        #1;
        check("single_cnt", cnt_out, 1);
        check("single_not_yet_valid", evt_valid, 0);
        @(negedge clock);
        check("single_valid", evt_valid, 1);
        check("single_id", evt_id, 2);
        check("single_ts", evt_ts, 5);
        evt_ready = 1'b1;
        @(negedge clock);
        evt_ready = 1'b0;
        check("single_popped", evt_valid, 0);

        // Simultaneous fires 4'b1011 at ts=9, consumer always ready.
        do_reset();
        wait_cyc(9);
        evt_ready = 1'b1;
        fire      = 4'b1011;
        @(negedge clock);
        fire = '0;
        @(negedge clock);
        check("simul_valid0", evt_valid, 1);
        check("simul_id0", evt_id, 0);
        check("simul_ts0", evt_ts, 9);
        @(negedge clock);
        check("simul_valid1", evt_valid, 1);
        check("simul_id1", evt_id, 1);
        check("simul_ts1", evt_ts, 9);
        @(negedge clock);
        check("simul_valid3", evt_valid, 1);
        check("simul_id3", evt_id, 3);
        check("simul_ts3", evt_ts, 9);
        @(negedge clock);
        check("simul_drained", evt_valid, 0);
        check("simul_overrun", overrun, 0);
        evt_ready = 1'b0;

        // Backpressure: fire[0] at ts 5..14 with the consumer stalled.
        do_reset();
        wait_cyc(5);
        for (int k = 0; k < 10; k++) begin
            fire = 4'b0001;
            @(negedge clock);
        end
        fire    = '0;
        cnt_sel = 2'd0;
        #1;
        check("bp_fifo_full", fifo_full, 1);
        check("bp_overrun", overrun, 4'b0001);
        check("bp_cnt", cnt_out, 10);
        check("bp_head_ts", evt_ts, 5);
        evt_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("bp_drain_valid", evt_valid, 1);
            check("bp_drain_id", evt_id, 0);
            check("bp_drain_ts", evt_ts, (k < 8) ? 5 + k : 14);
            @(negedge clock);
        end
        check("bp_drained", evt_valid, 0);
        check("bp_overrun_sticky", overrun, 4'b0001);
        evt_ready = 1'b0;

        // Saturation: 20 fires on checker 1 with the consumer stalled.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            fire = 4'b0010;
            @(negedge clock);
        end
        fire    = '0;
        cnt_sel = 2'd1;
        #1;
        check("sat_cnt", cnt_out, 15);
        check("sat_overrun", overrun, 4'b0010);
        check("sat_full", fifo_full, 1);

        // Clear in the same cycle as a fire: clear wins.
        clear = 1'b1;
        fire  = 4'b0010;
        @(negedge clock);
        clear = 1'b0;
        fire  = '0;
        #1;
        check("clr_cnt", cnt_out, 0);
        check("clr_valid", evt_valid, 0);
        check("clr_full", fifo_full, 0);
        check("clr_overrun", overrun, 0);
        @(negedge clock);
        check("clr_no_late_push", evt_valid, 0);

        // Enable low: fires ignored.
        enable = 1'b0;
        fire   = 4'b0001;
        @(negedge clock);
        fire    = '0;
        enable  = 1'b1;
        cnt_sel = 2'd0;
        #1;
        check("en_cnt", cnt_out, 0);
        @(negedge clock);
        check("en_no_event", evt_valid, 0);

        // Reset during drain: queue five events on checker 3, then reset.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            fire = 4'b1000;
            @(negedge clock);
        end
        fire = '0;
        @(negedge clock);
        check("mid_queued_valid", evt_valid, 1);
        check("mid_queued_id", evt_id, 3);
        evt_ready = 1'b1;
        reset     = 1'b0;
        #1;
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_full", fifo_full, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_no_stale1", evt_valid, 0);
        @(negedge clock);
        check("mid_no_stale2", evt_valid, 0);
        cnt_sel = 2'd3;
        #1;
        check("mid_cnt_cleared", cnt_out, 0);
        wait_cyc(3);
        fire = 4'b0001;
        @(negedge clock);
        fire = '0;
        @(negedge clock);
        check("mid_restart_valid", evt_valid, 1);
        check("mid_restart_id", evt_id, 0);
        check("mid_restart_ts", evt_ts, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
